// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants and bus-owner encoding
package mem_map_pkg;

  // First hardware-register address; RAM occupies 0 .. IO_BASE-1
  localparam logic [15:0] IO_BASE       = 16'h7F80;
  // Offset of the character output register inside the IO window
  localparam int          IO_OUT_OFFSET = 1;
  // Number of RAM words below the IO window
  localparam int          MEM_SIZE      = int'(IO_BASE);

  // Who drove the memory port in a given cycle
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_AUX  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/auxiliary arbiter for the shared main memory with IO decode
module mem_arbiter
  import mem_map_pkg::*;
#(
  parameter int WORD_SIZE   = 20,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  aux_req,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic                  aux_we,
  input  logic [WORD_SIZE-1:0]  aux_wdata,
  output logic                  aux_grant,
  output logic                  aux_rvalid,
  output logic [WORD_SIZE-1:0]  aux_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  io_wvalid,
  output logic [7:0]            io_wdata
);

  localparam int                    CNT_W       = $clog2(MAX_CPU_RUN + 1);
  localparam logic [CNT_W-1:0]      RUN_LIMIT   = CNT_W'(MAX_CPU_RUN);
  localparam logic [ADDR_WIDTH-1:0] IO_LO       = ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH-1:0] IO_OUT_ADDR = ADDR_WIDTH'(int'(IO_BASE) + IO_OUT_OFFSET);

  logic [CNT_W-1:0]      run_cnt;
  owner_t                prev_owner;
  owner_t                winner;
  logic [WORD_SIZE-1:0]  hold;
  logic                  io_rd;
  logic                  aux_wins;
  logic                  cpu_wins;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_we;
  logic [WORD_SIZE-1:0]  win_wdata;
  logic [WORD_SIZE-1:0]  rd_data;
  logic                  io_strobe;
  logic                  io_rd_next;

  // Pick one owner per cycle; aux only pre-empts the CPU after a full run of CPU grants
  always_comb begin
    aux_wins = 1'b0;
    cpu_wins = 1'b0;
    winner   = OWNER_NONE;
    if (!reset) begin
      aux_wins = aux_req && (!cpu_req || run_cnt == RUN_LIMIT);
      cpu_wins = cpu_req && !aux_wins;
    end
    if (aux_wins) begin
      winner = OWNER_AUX;
    end else if (cpu_wins) begin
      winner = OWNER_CPU;
    end
  end

  // Route the winner onto the memory port and decode the IO window
  always_comb begin
    win_addr   = aux_wins ? aux_addr  : cpu_addr;
    win_wdata  = aux_wins ? aux_wdata : cpu_wdata;
    win_we     = aux_wins ? aux_we    : (cpu_wins && cpu_we);
    io_strobe  = win_we && (win_addr == IO_OUT_ADDR);
    io_rd_next = (aux_wins || cpu_wins) && !win_we && (win_addr >= IO_LO);
  end

  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;
  assign mem_we    = win_we && (win_addr < IO_LO);
  assign cpu_stall = cpu_req && aux_wins;
  assign aux_grant = aux_wins;

  // Reads of the IO window return zero instead of whatever the RAM drives
  assign rd_data   = io_rd ? '0 : mem_rdata;
  assign cpu_rdata = (prev_owner == OWNER_CPU) ? rd_data : hold;
  assign aux_rdata = rd_data;

  // Count CPU grants that happen while aux is waiting; saturate at the run limit
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (aux_wins || !aux_req) begin
      run_cnt <= '0;
    end else if (cpu_wins && run_cnt != RUN_LIMIT) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // Remember last cycle's owner and read kind so the returning data can be steered
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_owner <= OWNER_NONE;
      io_rd      <= 1'b0;
      aux_rvalid <= 1'b0;
    end else begin
      prev_owner <= winner;
      io_rd      <= io_rd_next;
      aux_rvalid <= aux_wins && !aux_we;
    end
  end

  // Keep the last CPU read value so a stalled CPU still sees it on the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
    end else if (prev_owner == OWNER_CPU) begin
      hold <= rd_data;
    end
  end

  // Turn a write to the output register into a one-cycle character strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      io_wvalid <= 1'b0;
      io_wdata  <= 8'h00;
    end else begin
      io_wvalid <= io_strobe;
      if (io_strobe) begin
        io_wdata <= win_wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int W = 20;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [A-1:0] cpu_addr;
  logic         cpu_we;
  logic [W-1:0] cpu_wdata;
  logic [W-1:0] cpu_rdata;
  logic         cpu_stall;
  logic         aux_req;
  logic [A-1:0] aux_addr;
  logic         aux_we;
  logic [W-1:0] aux_wdata;
  logic         aux_grant;
  logic         aux_rvalid;
  logic [W-1:0] aux_rdata;
  logic [A-1:0] mem_addr;
  logic         mem_we;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         io_wvalid;
  logic [7:0]   io_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mem [0:65535];

  bit           exp_stall [0:12] = '{0,0,0,0,0,0,0,1,0,0,0,0,1};
  bit           aux_on    [0:12] = '{0,0,0,1,1,1,1,1,1,1,1,1,1};
  logic [W-1:0] exp_rd    [0:12] = '{20'h10000, 20'h10001, 20'h10002, 20'h10003,
                                     20'h10004, 20'h10005, 20'h10006, 20'h10006,
                                     20'h10007, 20'h10008, 20'h10009, 20'h1000A,
                                     20'h1000A};

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(A), .MAX_CPU_RUN(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_we     (aux_we),
    .aux_wdata  (aux_wdata),
    .aux_grant  (aux_grant),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .io_wvalid  (io_wvalid),
    .io_wdata   (io_wdata)
  );

  // Single-port RAM with registered address, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic req, input logic [A-1:0] addr, input logic we,
                         input logic [W-1:0] wdata);
    cpu_req   = req;
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wdata;
  endtask

  task automatic aux_set(input logic req, input logic [A-1:0] addr, input logic we,
                         input logic [W-1:0] wdata);
    aux_req   = req;
    aux_addr  = addr;
    aux_we    = we;
    aux_wdata = wdata;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 20'h12345;
    mem[16'h0020] = 20'h00ABC;
    mem[16'h7F81] = 20'hFFFFF;
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 20'h10000 + W'(i);

    // Reset: requests present but nothing may be granted or written
    reset = 1'b1;
    cpu_set(1'b0, 16'h0000, 1'b0, '0);
    aux_set(1'b1, 16'h0030, 1'b1, 20'h00777);
    @(negedge clk); #1;
    check("rst_aux_grant", aux_grant, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    check("rst_io_wvalid", io_wvalid, 0);
    check("rst_aux_rvalid", aux_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);

    @(negedge clk);
    reset = 1'b0;
    aux_set(1'b0, 16'h0000, 1'b0, '0);

    // CPU-only read
    @(negedge clk);
    cpu_set(1'b1, 16'h0010, 1'b0, '0);
    #1;
    check("cpu_only_stall", cpu_stall, 0);
    check("cpu_only_addr", mem_addr, 16'h0010);
    @(posedge clk); #1;
    check("cpu_only_rdata", cpu_rdata, 20'h12345);
    @(negedge clk);
    cpu_set(1'b0, 16'h0000, 1'b0, '0);
    @(posedge clk); #1;
    check("cpu_idle_hold", cpu_rdata, 20'h12345);

    // Aux-only read
    @(negedge clk);
    aux_set(1'b1, 16'h0020, 1'b0, '0);
    #1;
    check("aux_only_grant", aux_grant, 1);
    check("aux_only_stall", cpu_stall, 0);
    @(posedge clk); #1;
    check("aux_only_rvalid", aux_rvalid, 1);
    check("aux_only_rdata", aux_rdata, 20'h00ABC);
    @(negedge clk);
    aux_set(1'b0, 16'h0000, 1'b0, '0);
    @(posedge clk); #1;
    check("aux_rvalid_drop", aux_rvalid, 0);

    // Contention: CPU reads every cycle, aux rises on cycle 3 and stays up
    k = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      cpu_set(1'b1, 16'h0100 + A'(k), 1'b0, '0);
      aux_set(aux_on[c], 16'h0020, 1'b0, '0);
      #1;
      check($sformatf("cont_stall_%0d", c), cpu_stall, exp_stall[c]);
      check($sformatf("cont_grant_%0d", c), aux_grant, exp_stall[c]);
      check($sformatf("cont_addr_%0d", c), mem_addr,
            exp_stall[c] ? 16'h0020 : 16'h0100 + A'(k));
      @(posedge clk); #1;
      check($sformatf("cont_rdata_%0d", c), cpu_rdata, exp_rd[c]);
      check($sformatf("cont_rvalid_%0d", c), aux_rvalid, exp_stall[c]);
      if (exp_stall[c]) check($sformatf("cont_auxdata_%0d", c), aux_rdata, 20'h00ABC);
      if (!exp_stall[c]) k++;
    end
    @(negedge clk);
    cpu_set(1'b0, 16'h0000, 1'b0, '0);
    aux_set(1'b0, 16'h0000, 1'b0, '0);

    // IO output register write: strobe, no RAM write
    @(negedge clk);
    cpu_set(1'b1, 16'h7F81, 1'b1, 20'h00041);
    #1;
    check("io_out_mem_we", mem_we, 0);
    @(posedge clk); #1;
    check("io_out_wvalid", io_wvalid, 1);
    check("io_out_wdata", io_wdata, 8'h41);

    // Other IO address: ignored
    @(negedge clk);
    cpu_set(1'b1, 16'h7F90, 1'b1, 20'h00055);
    #1;
    check("io_other_mem_we", mem_we, 0);
    @(posedge clk); #1;
    check("io_other_wvalid", io_wvalid, 0);

    // RAM write by CPU, then aux reads it back on the next cycle
    @(negedge clk);
    cpu_set(1'b1, 16'h0050, 1'b1, 20'h0ABCD);
    #1;
    check("ram_wr_mem_we", mem_we, 1);
    @(posedge clk); #1;
    check("ram_wr_no_strobe", io_wvalid, 0);
    @(negedge clk);
    cpu_set(1'b0, 16'h0000, 1'b0, '0);
    aux_set(1'b1, 16'h0050, 1'b0, '0);
    #1;
    check("wr_rd_grant", aux_grant, 1);
    @(posedge clk); #1;
    check("wr_rd_rvalid", aux_rvalid, 1);
    check("wr_rd_rdata", aux_rdata, 20'h0ABCD);

    // IO read returns zero, then an ordinary read returns RAM data again
    @(negedge clk);
    aux_set(1'b0, 16'h0000, 1'b0, '0);
    cpu_set(1'b1, 16'h7F81, 1'b0, '0);
    @(posedge clk); #1;
    check("io_read_zero", cpu_rdata, 0);
    @(negedge clk);
    cpu_set(1'b1, 16'h0050, 1'b0, '0);
    @(posedge clk); #1;
    check("ram_read_after_io", cpu_rdata, 20'h0ABCD);

    // Reset in the cycle aux would be granted after a full CPU run
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_set(1'b1, 16'h0010, 1'b0, '0);
      aux_set(1'b1, 16'h0020, 1'b0, '0);
      #1;
      check($sformatf("pre_rst_stall_%0d", c), cpu_stall, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_grant", aux_grant, 0);
    check("mid_rst_stall", cpu_stall, 0);
    @(posedge clk); #1;
    check("mid_rst_rvalid", aux_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_stall", cpu_stall, 0);
    check("post_rst_grant", aux_grant, 0);
    @(posedge clk); #1;
    check("post_rst_rdata", cpu_rdata, 20'h12345);
    check("post_rst_rvalid", aux_rvalid, 0);

    @(negedge clk);
    cpu_set(1'b0, 16'h0000, 1'b0, '0);
    aux_set(1'b0, 16'h0000, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, 20-bit-word main memory between the stack CPU (primary port) and one auxiliary requester (DMA/loader/debug). Auxiliary examples: DMA engine, program loader, debug port.
- Decodes the hardware-register window at the top of the address space; writes to the output device register become a strobe instead of a RAM write.
- Sits between the CPU and the memory block. Inserts one-cycle CPU stalls when the auxiliary port is granted.

Parameters:
- WORD_SIZE, 20, data word width.
- ADDR_WIDTH, 16, address width.
- IO_BASE, 16'h7F80, first hardware-register address; RAM is 0 .. IO_BASE-1.
- IO_OUT_OFFSET, 1, output-device offset; write to IO_BASE+1 emits a character.
- MAX_CPU_RUN, 4, consecutive CPU grants allowed while aux is waiting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU access request this cycle.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_we  in  1  CPU write enable.
- cpu_wdata  in  WORD_SIZE  CPU write data.
- cpu_rdata  out  WORD_SIZE  CPU read data, valid one cycle after a granted read.
- cpu_stall  out  1  CPU must hold all state this cycle and reissue its request.
- aux_req  in  1  auxiliary request; held until granted.
- aux_addr  in  ADDR_WIDTH  auxiliary address.
- aux_we  in  1  auxiliary write enable.
- aux_wdata  in  WORD_SIZE  auxiliary write data.
- aux_grant  out  1  auxiliary access accepted this cycle.
- aux_rvalid  out  1  aux_rdata valid (cycle after a granted aux read).
- aux_rdata  out  WORD_SIZE  auxiliary read data.
- mem_addr  out  ADDR_WIDTH  to memory.
- mem_we  out  1  to memory.
- mem_wdata  out  WORD_SIZE  to memory.
- mem_rdata  in  WORD_SIZE  from memory; registered-address read, 1-cycle latency.
- io_wvalid  out  1  one-cycle strobe: output-device write.
- io_wdata  out  8  character written (wdata[7:0]).

Behaviour:
- Interfaces: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset state: run_cnt=0, prev_owner=NONE, hold=0, io_wvalid=0, io_wdata=0, aux_rvalid=0.
- Reset combinational outputs: cpu_stall=0, aux_grant=0, mem_we=0 whenever reset is high.
- Reset mid-transaction: any in-flight aux read is dropped; aux_rvalid does not fire.
- Arbitration (combinational, one grant per cycle):
  - Aux wins if aux_req && (!cpu_req || run_cnt==MAX_CPU_RUN); otherwise the CPU wins if cpu_req.
  - cpu_stall = cpu_req && aux wins.
  - aux_grant = aux wins.
- run_cnt:
  - Increments on a CPU grant while aux_req=1, saturating at MAX_CPU_RUN.
  - Cleared on an aux grant, and on any cycle with aux_req=0.
- Memory mux: mem_addr/mem_wdata come from the winner; mem_addr=cpu_addr when there is no grant.
- mem_we = winner_we && addr < IO_BASE. Writes at or above IO_BASE never reach RAM.
- IO writes:
  - A granted write to IO_BASE+IO_OUT_OFFSET registers io_wvalid=1 and io_wdata=wdata[7:0] for exactly one cycle, the cycle after the grant.
  - Other IO addresses are ignored on write.
  - IO reads return 0: a registered io_rd flag forces the returned data to 0.
- prev_owner register: records the winner (CPU/AUX/NONE) of the previous cycle.
- CPU read data:
  - cpu_rdata = mem_rdata when prev_owner==CPU, else hold.
  - hold <= the CPU-returned value whenever prev_owner==CPU.
  - Effect: data survives a stall cycle, because a stalled CPU re-consumes it next cycle.
- Aux read data: aux_rvalid=1 the cycle after a granted aux read; aux_rdata=mem_rdata in that cycle.
- Simultaneous write and read of the same address by different owners in consecutive cycles follows memory order: the later read sees the earlier write.
- Latency:
  - CPU without contention: zero added latency.
  - Aux: worst case MAX_CPU_RUN+1 cycles from aux_req to aux_grant.

Decomposition:
- Shared package mem_map_pkg: IO_BASE, IO_OUT_OFFSET, MEM_SIZE, and owner encoding (OWNER_NONE=0, OWNER_CPU=1, OWNER_AUX=2). It is reused by the CPU and memory blocks.
- No sub-module needed; the single module holds the arbiter, counter and return-path registers.

Test Plan:
- CPU-only: cpu reads 0x0010 (mem=0x12345) -> cpu_rdata=0x12345 next cycle, cpu_stall never asserted.
- Aux-only: aux_req read 0x0020 (mem=0x00ABC) -> aux_grant same cycle, aux_rvalid=1 with 0x00ABC next cycle.
- Contention, CPU request every cycle plus aux_req held:
  - Required: 4 CPU grants, then aux_grant with cpu_stall=1 for exactly one cycle, then the pattern repeats.
  - Required: the CPU read data issued before the stall is still presented on cpu_rdata during the cycle after the stall.
- IO write: cpu writes 0x00041 to 0x7F81 -> mem_we=0, io_wvalid=1 with io_wdata=0x41 one cycle later. Writing 0x7F90 -> no strobe, RAM unchanged.
- Reset mid-operation: assert reset in the cycle of an aux read grant -> aux_rvalid stays 0, run_cnt=0, first post-reset CPU access is unstalled.
